dbus_transfer_unit: RTL

Parametrised register-file and accumulator block behind a single shared internal data bus, driven by a command handshake. It replaces hand-wired per-register select/read-write lines with one command port, supports register-to-register moves and accumulator arithmetic, and splits the external data pins into in/out/enable so the pad-level tri-state lives only at the chip top.

---
 rtl/dbus_pkg.sv | 23 ++
 rtl/dbus_alu.sv | 45 ++++
 rtl/dbus_transfer_unit.sv | 134 +++++++++++++
 3 files changed

// File: rtl/dbus_pkg.sv
// Shared definitions for the dbus transfer unit: command opcodes,
// transfer FSM states and the opcode field width.
package dbus_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_NOP   = 3'd0,
        OP_LOAD  = 3'd1,
        OP_STORE = 3'd2,
        OP_MOVE  = 3'd3,
        OP_ADD   = 3'd4,
        OP_SUB   = 3'd5,
        OP_CLR   = 3'd6,
        OP_WB    = 3'd7
    } op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_XFER = 1'b1
    } state_e;

endpackage

// File: rtl/dbus_alu.sv
// Combinational accumulator adder/subtractor.
// Ports:
//   a      - accumulator operand
//   b      - bus operand
//   sub    - 1: a - b, 0: a + b
//   result - WIDTH-bit result (wrapped, or clamped when DBUS_SAT_EN is defined)
//   ovf    - carry-out on add, borrow on subtract
// Configuration macro: DBUS_SAT_EN (clamp to 2^WIDTH-1 on add overflow,
// to 0 on subtract underflow).
module dbus_alu #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] result,
    output logic             ovf
);

    logic [WIDTH:0] ext;

    // One extra bit captures carry on add and borrow on subtract.
    always_comb begin
        if (sub) begin
            ext = {1'b0, a} - {1'b0, b};
        end else begin
            ext = {1'b0, a} + {1'b0, b};
        end
    end

    assign ovf = ext[WIDTH];

`ifdef DBUS_SAT_EN
    always_comb begin
        if (ext[WIDTH]) begin
            result = sub ? '0 : '1;
        end else begin
            result = ext[WIDTH-1:0];
        end
    end
`else
    assign result = ext[WIDTH-1:0];
`endif

endmodule

// File: rtl/dbus_transfer_unit.sv
// Register file plus accumulator behind one shared internal bus register,
// driven by a valid/ready command port. Each command takes two cycles:
// the acceptance edge loads the bus from the source, the exit edge of the
// XFER cycle commits the single destination.
// Ports:
//   Clock, Resetn          - rising-edge clock, async active-low reset
//   CmdValid/CmdReady      - command handshake
//   CmdOp/CmdSrc/CmdDst    - opcode and register indices
//   DioIn/DioOut/DioOe     - split external data pins (DioOut mirrors the bus)
//   RspValid               - high during the XFER cycle of a STORE
//   Acc/Ovf                - accumulator and sticky overflow flag
// Configuration macro: DBUS_SAT_EN (saturating ADD/SUB in dbus_alu).
module dbus_transfer_unit
    import dbus_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NREGS = 4,
    parameter int IW    = $clog2(NREGS)
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic             CmdValid,
    output logic             CmdReady,
    input  logic [OP_W-1:0]  CmdOp,
    input  logic [IW-1:0]    CmdSrc,
    input  logic [IW-1:0]    CmdDst,
    input  logic [WIDTH-1:0] DioIn,
    output logic [WIDTH-1:0] DioOut,
    output logic             DioOe,
    output logic             RspValid,
    output logic [WIDTH-1:0] Acc,
    output logic             Ovf
);

    state_e           state;
    op_e              op_q;
    logic [IW-1:0]    dst_q;
    logic [WIDTH-1:0] bus;
    logic [WIDTH-1:0] acc;
    logic             ovf;
    logic             ready;
    logic             oe;
    logic             rsp;
    logic [WIDTH-1:0] regs [NREGS];

    op_e              cmd_op;
    logic [WIDTH-1:0] alu_result;
    logic             alu_ovf;

    assign cmd_op = op_e'(CmdOp);

    // The ALU always sees the latched bus value; it is only used at the
    // exit edge of an ADD/SUB.
    dbus_alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .a      (acc),
        .b      (bus),
        .sub    (op_q == OP_SUB),
        .result (alu_result),
        .ovf    (alu_ovf)
    );

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state <= S_IDLE;
            ready <= 1'b1;
            op_q  <= OP_NOP;
            dst_q <= '0;
            bus   <= '0;
            acc   <= '0;
            ovf   <= 1'b0;
            oe    <= 1'b0;
            rsp   <= 1'b0;
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (CmdValid) begin
                        state <= S_XFER;
                        ready <= 1'b0;
                        op_q  <= cmd_op;
                        dst_q <= CmdDst;
                        // Pins are driven only while a STORE is on the bus.
                        oe    <= (cmd_op == OP_STORE);
                        rsp   <= (cmd_op == OP_STORE);
                        case (cmd_op)
                            OP_LOAD:                        bus <= DioIn;
                            OP_STORE, OP_MOVE,
                            OP_ADD, OP_SUB:                 bus <= regs[CmdSrc];
                            OP_WB:                          bus <= acc;
                            default:                        bus <= '0;
                        endcase
                    end
                end
                S_XFER: begin
                    state <= S_IDLE;
                    ready <= 1'b1;
                    oe    <= 1'b0;
                    rsp   <= 1'b0;
                    case (op_q)
                        OP_LOAD, OP_MOVE, OP_WB: regs[dst_q] <= bus;
                        OP_ADD, OP_SUB: begin
                            acc <= alu_result;
                            // Sticky: only CLR or reset clears it.
                            if (alu_ovf) begin
                                ovf <= 1'b1;
                            end
                        end
                        OP_CLR: begin
                            acc <= '0;
                            ovf <= 1'b0;
                        end
                        default: ;
                    endcase
                end
                default: begin
                    state <= S_IDLE;
                    ready <= 1'b1;
                end
            endcase
        end
    end

    assign CmdReady = ready;
    assign DioOut   = bus;
    assign DioOe    = oe;
    assign RspValid = rsp;
    assign Acc      = acc;
    assign Ovf      = ovf;

endmodule
